// File: rtl/mips_hazard_ctrl.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight destinations driving
// load-use stalls, branch flushes and registered EX forwarding selects. Macro: MIPS_HAZARD_STATS_EN.
module mips_hazard_ctrl #(
  parameter int  REG_AW      = 5,
  parameter int  PIPE_STAGES = 3,
  parameter int  LOAD_SLOT   = 2,
  parameter int  BR_SLOT     = 1,
  localparam int FW          = $clog2(PIPE_STAGES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [REG_AW-1:0]  id_rw,
  input  logic               id_regwrite,
  input  logic               id_load,
  input  logic               br_taken,
  output logic               pc_hold,
  output logic               ifid_hold,
  output logic               ifid_clr,
  output logic               idex_clr,
  output logic [BR_SLOT-1:0] flush_vec,
  output logic [FW-1:0]      fwd_a,
  output logic [FW-1:0]      fwd_b,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
);

  // Slot PIPE_STAGES-1 writes the RF through at this edge and is never a forwarding
  // source, so only slots 0..PIPE_STAGES-2 are actually stored.
  localparam int SB_D = PIPE_STAGES - 1;

  logic [SB_D-1:0]   sb_vld_q, sb_vld_d;
  logic [SB_D-1:0]   sb_wr_q, sb_wr_d;
  logic [SB_D-1:0]   sb_ld_q, sb_ld_d;
  logic [REG_AW-1:0] sb_dst_q [SB_D];
  logic [REG_AW-1:0] sb_dst_d [SB_D];

  logic [FW-1:0] fwd_a_q, fwd_a_d;
  logic [FW-1:0] fwd_b_q, fwd_b_d;

  logic [FW-1:0] sel_a, sel_b;
  logic          haz_a, haz_b;
  logic          load_use, stall, br_live;

  function automatic logic src_hit(input logic vld, input logic wr,
                                   input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] src,
                                   input logic use_src);
    return vld && wr && use_src && (src != '0) && (dst == src);
  endfunction

  // Lookup: scan oldest to youngest so the lowest matching slot wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int s = SB_D - 1; s >= 0; s--) begin
      if (src_hit(sb_vld_q[s], sb_wr_q[s], sb_dst_q[s], id_rs, id_use_rs)) begin
        sel_a = FW'(s + 1);
        haz_a = sb_ld_q[s] && ((s + 1) < LOAD_SLOT);
      end
      if (src_hit(sb_vld_q[s], sb_wr_q[s], sb_dst_q[s], id_rt, id_use_rt)) begin
        sel_b = FW'(s + 1);
        haz_b = sb_ld_q[s] && ((s + 1) < LOAD_SLOT);
      end
    end
  end

  // Hazard/flush decisions: reset masks everything, branch beats stall.
  assign load_use  = id_valid & (haz_a | haz_b);
  assign br_live   = rst & br_taken;
  assign stall     = rst & load_use & ~br_taken;

  assign pc_hold   = stall;
  assign ifid_hold = stall;
  assign idex_clr  = stall | br_live;
  assign ifid_clr  = br_live;
  assign flush_vec = {BR_SLOT{br_live}};

  // Scoreboard advance, flush of slots 1..BR_SLOT, and select capture for slot0.
  always_comb begin
    sb_vld_d    = '0;
    sb_wr_d     = '0;
    sb_ld_d     = '0;
    sb_vld_d[0] = id_valid & ~idex_clr;
    sb_wr_d[0]  = id_regwrite;
    sb_ld_d[0]  = id_load;
    sb_dst_d[0] = id_rw;
    for (int s = 1; s < SB_D; s++) begin
      sb_vld_d[s] = sb_vld_q[s-1] & ~(br_live & (s <= BR_SLOT));
      sb_wr_d[s]  = sb_wr_q[s-1];
      sb_ld_d[s]  = sb_ld_q[s-1];
      sb_dst_d[s] = sb_dst_q[s-1];
    end
    fwd_a_d = sb_vld_d[0] ? sel_a : '0;
    fwd_b_d = sb_vld_d[0] ? sel_b : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_vld_q <= '0;
      fwd_a_q  <= '0;
      fwd_b_q  <= '0;
    end else begin
      sb_vld_q <= sb_vld_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  // Payload fields are qualified by sb_vld_q and need no reset.
  always_ff @(posedge clk) begin
    sb_wr_q  <= sb_wr_d;
    sb_ld_q  <= sb_ld_d;
    sb_dst_q <= sb_dst_d;
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef MIPS_HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
    flush_cnt_d = sat_inc(flush_cnt_q, br_live);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Directed bench for mips_hazard_ctrl: default build plus a PIPE_STAGES=4/LOAD_SLOT=3/BR_SLOT=2 copy.
module tb_mips_hazard_ctrl;

`ifdef MIPS_HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_load, br_taken;
  logic [4:0] id_rs, id_rt, id_rw;

  logic        pc_hold, ifid_hold, ifid_clr, idex_clr;
  logic [0:0]  flush_vec;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt, flush_cnt;

  logic        pc_hold2, ifid_hold2, ifid_clr2, idex_clr2;
  logic [1:0]  flush_vec2;
  logic [1:0]  fwd_a2, fwd_b2;
  logic [31:0] stall_cnt2, flush_cnt2;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  always #5 clk = ~clk;

  mips_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw),
    .id_regwrite(id_regwrite), .id_load(id_load), .br_taken(br_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .flush_vec(flush_vec), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  mips_hazard_ctrl #(.REG_AW(5), .PIPE_STAGES(4), .LOAD_SLOT(3), .BR_SLOT(2)) u_dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rw(id_rw),
    .id_regwrite(id_regwrite), .id_load(id_load), .br_taken(br_taken),
    .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .ifid_clr(ifid_clr2), .idex_clr(idex_clr2),
    .flush_vec(flush_vec2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  // One ID cycle: inputs change on the falling edge, outputs sampled 1 time unit later.
  task automatic cyc(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] rw,
                     input logic wr, input logic ld, input logic br);
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rw = rw; id_regwrite = wr; id_load = ld; br_taken = br;
    #1;
  endtask

  task automatic nop();
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) nop();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    checks++; if (ifid_clr !== 1'b0) begin errors++; $display("FAIL rst_ifid_clr got=%b exp=0", ifid_clr); end
    checks++; if (idex_clr !== 1'b0) begin errors++; $display("FAIL rst_idex_clr got=%b exp=0", idex_clr); end
    checks++; if (flush_vec2 !== 2'b00) begin errors++; $display("FAIL rst_flush_vec2 got=%b exp=00", flush_vec2); end
    nop();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL rst_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL rst_pc_hold got=%b exp=0", pc_hold); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    rst = 1'b1;
    drain();
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add $3,$1,$2
    cyc(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);   // sub $4,$3,$5
    checks++; if (pc_hold !== 1'b0 || idex_clr !== 1'b0) begin errors++; $display("FAIL b2b_nostall got=%b/%b exp=0/0", pc_hold, idex_clr); end
    nop();
    checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL b2b_fwd_a got=%0d exp=1", fwd_a); end
    checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL b2b_fwd_b got=%0d exp=0", fwd_b); end
  endtask

  task automatic test_one_gap();
    drain();
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add $3
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);   // nop
    cyc(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);   // reads rt=$3
    nop();
    checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL gap_fwd_b got=%0d exp=2", fwd_b); end
    checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL gap_fwd_a got=%0d exp=0", fwd_a); end
  endtask

  task automatic test_double_match();
    drain();
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // add $3
    cyc(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);   // or  $3
    cyc(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    nop();
    checks++; if (fwd_a !== 2'd1 || fwd_b !== 2'd1) begin errors++; $display("FAIL dbl_fwd got=%0d/%0d exp=1/1", fwd_a, fwd_b); end
  endtask

  task automatic test_reg_zero();
    drain();
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);   // add $0
    cyc(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw $0
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL zero_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
    cyc(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL zero_load_stall got=%b exp=0", pc_hold); end
    nop();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL zero_fwd_ld got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
  endtask

  task automatic test_load_use();
    int n;
    drain();
    cyc(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw $5
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // add $6,$5,$5
    checks++; if (pc_hold !== 1'b1 || ifid_hold !== 1'b1 || idex_clr !== 1'b1 || ifid_clr !== 1'b0)
      begin errors++; $display("FAIL lu_stall got=%b%b%b%b exp=1110", pc_hold, ifid_hold, idex_clr, ifid_clr); end
    exp_stall++;
    n = 0;
    while (pc_hold === 1'b1 && n < 8) begin
      n++;
      cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (n != 1) begin errors++; $display("FAIL lu_stall_len got=%0d exp=1", n); end
    nop();
    checks++; if (fwd_a !== 2'd2 || fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd got=%0d/%0d exp=2/2", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== (STATS ? 32'(exp_stall) : 32'd0)) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, STATS ? exp_stall : 0); end
  endtask

  task automatic test_pipe4_load_use();
    int n;
    drain();
    cyc(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw $5
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (pc_hold2 !== 1'b1 || idex_clr2 !== 1'b1) begin errors++; $display("FAIL p4_stall got=%b/%b exp=1/1", pc_hold2, idex_clr2); end
    exp_stall++;   // the default instance also stalls once here
    n = 0;
    while (pc_hold2 === 1'b1 && n < 8) begin
      n++;
      cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    end
    checks++; if (n != 2) begin errors++; $display("FAIL p4_stall_len got=%0d exp=2", n); end
    nop();
    checks++; if (fwd_a2 !== 2'd3 || fwd_b2 !== 2'd3) begin errors++; $display("FAIL p4_fwd got=%0d/%0d exp=3/3", fwd_a2, fwd_b2); end
  endtask

  task automatic test_flush_priority();
    drain();
    cyc(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw $5
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);   // consumer + branch taken
    checks++; if (ifid_clr !== 1'b1 || idex_clr !== 1'b1) begin errors++; $display("FAIL fl_clr got=%b/%b exp=1/1", ifid_clr, idex_clr); end
    checks++; if (flush_vec !== 1'b1) begin errors++; $display("FAIL fl_vec got=%b exp=1", flush_vec); end
    checks++; if (pc_hold !== 1'b0 || ifid_hold !== 1'b0) begin errors++; $display("FAIL fl_hold got=%b/%b exp=0/0", pc_hold, ifid_hold); end
    checks++; if (flush_vec2 !== 2'b11 || pc_hold2 !== 1'b0) begin errors++; $display("FAIL fl_p4 got=%b/%b exp=11/0", flush_vec2, pc_hold2); end
    exp_flush++;
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL fl_post_stall got=%b exp=0", pc_hold); end
    checks++; if (stall_cnt !== (STATS ? 32'(exp_stall) : 32'd0)) begin errors++; $display("FAIL fl_stall_cnt got=%0d exp=%0d", stall_cnt, STATS ? exp_stall : 0); end
    checks++; if (flush_cnt !== (STATS ? 32'(exp_flush) : 32'd0)) begin errors++; $display("FAIL fl_flush_cnt got=%0d exp=%0d", flush_cnt, STATS ? exp_flush : 0); end
    nop();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL fl_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
  endtask

  task automatic test_reset_mid_stall();
    drain();
    cyc(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw $5
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rms_stall got=%b exp=1", pc_hold); end
    rst = 1'b0;
    #1;
    checks++; if (pc_hold !== 1'b0 || idex_clr !== 1'b0) begin errors++; $display("FAIL rms_in_rst got=%b/%b exp=0/0", pc_hold, idex_clr); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    checks++; if (pc_hold !== 1'b0 || idex_clr !== 1'b0) begin errors++; $display("FAIL rms_after got=%b/%b exp=0/0", pc_hold, idex_clr); end
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL rms_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rms_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    nop();
    checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL rms_fwd_next got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_rw = '0; id_regwrite = 1'b0; id_load = 1'b0; br_taken = 1'b0;
    test_reset();
    test_back_to_back();
    test_one_gap();
    test_double_match();
    test_reg_zero();
    test_load_use();
    test_pipe4_load_use();
    test_flush_priority();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
